// File: rtl/h264_pkg.sv
// Shared types and frame geometry for the H.264 luma/chroma schedulers.
package h264_pkg;

    localparam int FRAME_WIDTH  = 320;
    localparam int FRAME_HEIGHT = 240;
    localparam int MB_COLS_DEF  = FRAME_WIDTH / 16;
    localparam int MB_ROWS_DEF  = FRAME_HEIGHT / 16;

    // Index of the last 4x4 block in a 16x16 macroblock
    localparam logic [3:0] BLK_LAST = 4'd15;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LAUNCH,
        RUN,
        ADV
    } sched_state_e;

    typedef logic [5:0] mb_coord_t;

endpackage

// File: rtl/mb_raster_counter.sv
// Raster-order macroblock coordinate counter: x runs fastest, wraps into y.
// Shared between the luma and chroma schedulers.
module mb_raster_counter
    import h264_pkg::*;
#(
    parameter int MB_COLS = MB_COLS_DEF,
    parameter int MB_ROWS = MB_ROWS_DEF
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      clear,
    input  logic      advance,
    output mb_coord_t x_o,
    output mb_coord_t y_o,
    output logic      last_o
);

    localparam mb_coord_t X_MAX = mb_coord_t'(MB_COLS - 1);
    localparam mb_coord_t Y_MAX = mb_coord_t'(MB_ROWS - 1);

    mb_coord_t x_q, x_d;
    mb_coord_t y_q, y_d;

    // Next coordinates: clear wins over advance; a full frame wraps back to (0,0)
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear) begin
            x_d = '0;
            y_d = '0;
        end else if (advance) begin
            if (x_q == X_MAX) begin
                x_d = '0;
                y_d = (y_q == Y_MAX) ? '0 : y_q + 6'd1;
            end else begin
                x_d = x_q + 6'd1;
            end
        end
    end

    // Coordinate registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = (x_q == X_MAX) && (y_q == Y_MAX);

endmodule

// File: rtl/intra_mb_scheduler.sv
// Frame-level sequencer for the luma intra-4x4 path.
//
//  state  | meaning
//  IDLE   | waiting for start_i
//  FETCH  | fetch_req_o held until the fetch unit acks the MB
//  LAUNCH | waiting for the intra engine; one-cycle intra_valid_o launch
//  RUN    | counting the 16 4x4 blocks as CAVLC retires them
//  ADV    | step to the next MB, or finish the frame
module intra_mb_scheduler
    import h264_pkg::*;
#(
    parameter int MB_COLS = MB_COLS_DEF,
    parameter int MB_ROWS = MB_ROWS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       abort_i,
    output logic       fetch_req_o,
    input  logic       fetch_ack_i,
    output logic [5:0] fetch_mb_x_o,
    output logic [5:0] fetch_mb_y_o,
    input  logic       intra_ready_i,
    output logic       intra_valid_o,
    input  logic       dctq_valid_i,
    input  logic       cavlc_ready_i,
    output logic [3:0] blk_idx_o,
    output logic       mb_done_o,
    output logic       frame_done_o,
    output logic       busy_o
);

    sched_state_e state_q, state_d;
    logic [3:0]   blk_q, blk_d;
    logic         retire;
    logic         cnt_clear;
    logic         cnt_adv;
    logic         last_mb;
    mb_coord_t    mb_x;
    mb_coord_t    mb_y;

    assign retire = dctq_valid_i && cavlc_ready_i;

    mb_raster_counter #(
        .MB_COLS (MB_COLS),
        .MB_ROWS (MB_ROWS)
    ) u_raster (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .advance (cnt_adv),
        .x_o     (mb_x),
        .y_o     (mb_y),
        .last_o  (last_mb)
    );

    // Next-state and strobes; abort overrides every transition and suppresses all pulses
    always_comb begin
        state_d       = state_q;
        blk_d         = blk_q;
        cnt_clear     = 1'b0;
        cnt_adv       = 1'b0;
        fetch_req_o   = 1'b0;
        intra_valid_o = 1'b0;
        mb_done_o     = 1'b0;
        frame_done_o  = 1'b0;
        if (abort_i) begin
            state_d   = IDLE;
            blk_d     = '0;
            cnt_clear = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d   = FETCH;
                        blk_d     = '0;
                        cnt_clear = 1'b1;
                    end
                end
                FETCH: begin
                    fetch_req_o = 1'b1;
                    if (fetch_ack_i) begin
                        state_d = LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (intra_ready_i) begin
                        intra_valid_o = 1'b1;
                        state_d       = RUN;
                    end
                end
                RUN: begin
                    if (retire) begin
                        if (blk_q == BLK_LAST) begin
                            mb_done_o = 1'b1;
                            blk_d     = '0;
                            state_d   = ADV;
                        end else begin
                            blk_d = blk_q + 4'd1;
                        end
                    end
                end
                ADV: begin
                    if (last_mb) begin
                        frame_done_o = 1'b1;
                        cnt_clear    = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        cnt_adv = 1'b1;
                        state_d = FETCH;
                    end
                end
                default: begin
                    state_d = IDLE;
                    blk_d   = '0;
                end
            endcase
        end
    end

    // State and block-index registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
        end
    end

    assign fetch_mb_x_o = mb_x;
    assign fetch_mb_y_o = mb_y;
    assign blk_idx_o    = blk_q;
    assign busy_o       = (state_q != IDLE);

    // A retire seen outside RUN must leave the block counter untouched
    assert property (@(posedge clk) disable iff (rst)
        (retire && (state_q != RUN)) |=> $stable(blk_q));

endmodule
